// File: rtl/photon_pulse_emulator.sv
// Photon-counting PMT emulator: light-triggered exponential-decay emission plus optional dark counts.
// Optional feature: define EMU_DARK_COUNT_EN to enable LFSR-driven dark counts (dark_prob port is otherwise ignored).
module photon_pulse_emulator #(
  parameter logic [31:0] SEED        = 32'hACE1_2468,
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned DEAD_TIME   = 10
) (
  input  logic        main_clock,
  input  logic        reset,
  input  logic        light_in,
  input  logic        enable,
  input  logic [15:0] delay_cycles,
  input  logic [3:0]  decay_shift,
  input  logic [15:0] base_prob,
  input  logic [15:0] dark_prob,
  output logic        pmt_out,
  output logic [31:0] pulse_count,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    DECAY = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [8:0]  EMIT_LOAD = 9'(PULSE_WIDTH + DEAD_TIME);
  localparam logic [8:0]  DEAD_LIM  = 9'(DEAD_TIME);

  // Input synchronizer and edge detector
  logic light_meta;
  logic light_sync;
  logic light_prev;
  logic light_edge;

  // Random source
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [15:0] rnd;

  // Decay state machine
  state_t      state;
  state_t      state_n;
  logic [15:0] delay_cnt;
  logic [15:0] delay_cnt_n;
  logic [19:0] elapsed;
  logic [19:0] elapsed_n;
  logic [19:0] decay_step;
  logic [19:0] decay_limit;
  logic [15:0] prob;

  // Emitter
  logic        decay_hit;
  logic        dark_hit;
  logic        emit_idle;
  logic        fire;
  logic [8:0]  emit_cnt;
  logic [31:0] pulse_total;

  assign light_edge = light_sync & ~light_prev;
  assign lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
  assign rnd        = lfsr[15:0];

  always_ff @(posedge main_clock) begin
    if (reset) begin
      light_meta <= 1'b0;
      light_sync <= 1'b0;
      light_prev <= 1'b0;
      lfsr       <= LFSR_INIT;
    end else begin
      light_meta <= light_in;
      light_sync <= light_meta;
      light_prev <= light_sync;
      lfsr       <= lfsr_next;
    end
  end

  // Probability halves every 2^decay_shift clocks; 16 or more halvings leave nothing.
  assign decay_step  = elapsed >> decay_shift;
  assign decay_limit = 20'd16 << decay_shift;
  assign prob        = (decay_step >= 20'd16) ? 16'd0 : (base_prob >> decay_step[3:0]);

  always_ff @(posedge main_clock) begin
    if (reset) begin
      state     <= IDLE;
      delay_cnt <= 16'd0;
      elapsed   <= 20'd0;
    end else begin
      state     <= state_n;
      delay_cnt <= delay_cnt_n;
      elapsed   <= elapsed_n;
    end
  end

  // A detected edge always wins: it retriggers from any state and discards an old decay.
  always_comb begin
    state_n     = state;
    delay_cnt_n = delay_cnt;
    elapsed_n   = elapsed;
    if (light_edge) begin
      elapsed_n = 20'd0;
      if (delay_cycles == 16'd0) begin
        state_n     = DECAY;
        delay_cnt_n = 16'd0;
      end else begin
        state_n     = DELAY;
        delay_cnt_n = delay_cycles;
      end
    end else begin
      case (state)
        DELAY: begin
          if (delay_cnt <= 16'd1) begin
            state_n     = DECAY;
            delay_cnt_n = 16'd0;
            elapsed_n   = 20'd0;
          end else begin
            delay_cnt_n = delay_cnt - 16'd1;
          end
        end
        DECAY: begin
          if ((prob == 16'd0) || (elapsed >= decay_limit)) begin
            state_n   = IDLE;
            elapsed_n = 20'd0;
          end else begin
            elapsed_n = elapsed + 20'd1;
          end
        end
        default: begin
          state_n     = IDLE;
          delay_cnt_n = 16'd0;
          elapsed_n   = 20'd0;
        end
      endcase
    end
  end

`ifdef EMU_DARK_COUNT_EN
  assign dark_hit = (rnd < dark_prob);
`else
  logic unused_dark;
  assign dark_hit    = 1'b0;
  assign unused_dark = ^dark_prob;
`endif

  // emit_cnt holds the clocks left in high+dead; the last dead clock may already fire,
  // which gives a back-to-back period of exactly PULSE_WIDTH+DEAD_TIME.
  assign emit_idle = (emit_cnt <= 9'd1);
  assign decay_hit = (state == DECAY) && (rnd < prob);
  assign fire      = enable && emit_idle && (decay_hit || dark_hit);

  // Counting fires equals counting rising edges whenever DEAD_TIME is nonzero.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      emit_cnt    <= 9'd0;
      pmt_out     <= 1'b0;
      pulse_total <= 32'd0;
    end else if (fire) begin
      emit_cnt <= EMIT_LOAD;
      pmt_out  <= 1'b1;
      if (pulse_total != 32'hFFFF_FFFF) begin
        pulse_total <= pulse_total + 32'd1;
      end
    end else if (emit_cnt != 9'd0) begin
      emit_cnt <= emit_cnt - 9'd1;
      pmt_out  <= ((emit_cnt - 9'd1) > DEAD_LIM);
    end else begin
      pmt_out <= 1'b0;
    end
  end

  assign pulse_count = pulse_total;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_photon_pulse_emulator.sv
// Bench for photon_pulse_emulator: scheduled pulse-rise scoreboard plus pulse-shape monitor.
module tb_photon_pulse_emulator;

  localparam int          PW     = 4;
  localparam int          DT     = 10;
  localparam logic [31:0] SEED_V = 32'hACE1_2468;

  logic        main_clock;
  logic        reset;
  logic        light_in;
  logic        enable;
  logic [15:0] delay_cycles;
  logic [3:0]  decay_shift;
  logic [15:0] base_prob;
  logic [15:0] dark_prob;
  logic        pmt_out;
  logic [31:0] pulse_count;
  logic        busy;
  logic [1:0]  state_dbg;

  photon_pulse_emulator #(
    .SEED(SEED_V),
    .PULSE_WIDTH(PW),
    .DEAD_TIME(DT)
  ) dut (
    .main_clock(main_clock),
    .reset(reset),
    .light_in(light_in),
    .enable(enable),
    .delay_cycles(delay_cycles),
    .decay_shift(decay_shift),
    .base_prob(base_prob),
    .dark_prob(dark_prob),
    .pmt_out(pmt_out),
    .pulse_count(pulse_count),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock and cycle count
  initial main_clock = 1'b0;
  always #5 main_clock = ~main_clock;

  int unsigned cyc = 0;
  always @(posedge main_clock) cyc <= cyc + 1;

  // Scoreboard state
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rises = 0;
  int busy_rises = 0;
  int high_len = 0;
  int low_len = 0;
  bit have_prev = 0;
  bit shape_en = 0;
  logic prev_pmt = 1'b0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pulse shape, rise timing against the queue, busy rise count.
  always @(negedge main_clock) begin
    if (pmt_out === 1'b1 && prev_pmt == 1'b0) begin
      rises++;
      if (shape_en && have_prev) check("dead_gap_ok", 32'(low_len >= DT), 32'd1);
      if (exp_q.size() > 0) check("rise_cycle", cyc, exp_q.pop_front());
      have_prev = 1;
      high_len  = 1;
    end else if (pmt_out === 1'b1) begin
      high_len++;
    end
    if (pmt_out === 1'b0 && prev_pmt == 1'b1) begin
      if (shape_en) check("pulse_high_len", high_len, PW);
      low_len = 1;
    end else if (pmt_out === 1'b0) begin
      low_len++;
    end
    if (busy === 1'b1 && prev_busy == 1'b0) busy_rises++;
    prev_pmt  = (pmt_out === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge main_clock);
    #1;
  endtask

  task automatic tick_until(input int unsigned t);
    if (cyc < t) tick(int'(t - cyc));
  endtask

  task automatic wait_idle(input int budget, output int unsigned at);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic light_edge(input int hold);
    light_in = 1'b1;
    tick(hold);
    light_in = 1'b0;
  endtask

  int unsigned n0;
  int unsigned m0;
  int unsigned t_idle;
  int rise_base;
  int rb;
  int br0;

  initial begin
    reset = 1'b1;
    light_in = 1'b0;
    enable = 1'b1;
    delay_cycles = 16'd0;
    decay_shift = 4'd0;
    base_prob = 16'd0;
    dark_prob = 16'd0;
    tick(3);
    check("rst_pmt", pmt_out, 32'd0);
    check("rst_count", pulse_count, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_state", state_dbg, 32'd0);
    check("rst_lfsr", dut.lfsr, SEED_V);
    reset = 1'b0;
    tick(2);
    shape_en = 1;
    rise_base = rises;

    // Single edge, long delay: first rises deterministic while prob is full scale.
    delay_cycles = 16'd100;
    base_prob = 16'hFFFF;
    decay_shift = 4'd4;
    n0 = cyc;
    exp_q.push_back(n0 + 104);
    exp_q.push_back(n0 + 118);
    light_in = 1'b1;
    tick(2);
    check("t1_busy_pre", busy, 32'd0);
    tick(1);
    check("t1_busy_on", busy, 32'd1);
    check("t1_state_delay", state_dbg, 32'd1);
    light_in = 1'b0;
    tick_until(n0 + 102);
    check("t1_state_delay_end", state_dbg, 32'd1);
    tick(1);
    check("t1_state_decay", state_dbg, 32'd2);
    wait_idle(600, t_idle);
    check("t1_idle_cycle", t_idle, n0 + 360);
    check("t1_sb_drain", exp_q.size(), 32'd0);
    check("t1_count", pulse_count, rises - rise_base);

    // Retrigger 50 clocks into DECAY.
    delay_cycles = 16'd20;
    n0 = cyc;
    exp_q.push_back(n0 + 24);
    exp_q.push_back(n0 + 38);
    light_edge(5);
    tick_until(n0 + 73);
    m0 = cyc;
    light_edge(4);
    exp_q.push_back(m0 + 24);
    exp_q.push_back(m0 + 38);
    for (int i = 0; i < 30; i++) begin
      check("t2_busy_hold", busy, 32'd1);
      tick(1);
    end
    wait_idle(600, t_idle);
    check("t2_idle_cycle", t_idle, m0 + 280);
    check("t2_sb_drain", exp_q.size(), 32'd0);
    check("t2_count", pulse_count, rises - rise_base);

    // Zero probabilities over many edges: busy per edge, never a pulse.
    base_prob = 16'd0;
    dark_prob = 16'd0;
    delay_cycles = 16'd3;
    rb = rises;
    br0 = busy_rises;
    for (int i = 0; i < 1000; i++) begin
      light_edge(2);
      tick(8);
    end
    check("t3_no_rises", rises - rb, 32'd0);
    check("t3_busy_edges", busy_rises - br0, 32'd1000);
    check("t3_count", pulse_count, rises - rise_base);

    // Reset on the second clock of a pulse.
    shape_en = 0;
    delay_cycles = 16'd0;
    base_prob = 16'hFFFF;
    n0 = cyc;
    light_edge(2);
    tick_until(n0 + 5);
    check("t4_pulse_on", pmt_out, 32'd1);
    reset = 1'b1;
    tick(1);
    check("t4_pmt_drop", pmt_out, 32'd0);
    check("t4_count_clr", pulse_count, 32'd0);
    check("t4_busy_clr", busy, 32'd0);
    check("t4_lfsr_seed", dut.lfsr, SEED_V);
    reset = 1'b0;
    base_prob = 16'd0;
    tick(20);
    rise_base = rises;
    shape_en = 1;

    // Dark counts with light static low.
    dark_prob = 16'hFFFF;
    n0 = cyc;
`ifdef EMU_DARK_COUNT_EN
    exp_q.push_back(n0 + 1);
    exp_q.push_back(n0 + 15);
    exp_q.push_back(n0 + 29);
    tick(50);
    dark_prob = 16'd0;
    tick(20);
    check("t5_dark_drain", exp_q.size(), 32'd0);
    check("t5_dark_count", pulse_count, rises - rise_base);
`else
    rb = rises;
    tick(60);
    check("t5_no_dark", rises - rb, 32'd0);
    check("t5_count", pulse_count, 32'd0);
    dark_prob = 16'd0;
    tick(20);
`endif

    // Saturation with a backdoor preload; enable drop mid-pulse.
    @(negedge main_clock);
    force dut.pulse_total = 32'hFFFF_FFFE;
    #1;
    release dut.pulse_total;
    tick(1);
    check("t6_preload", pulse_count, 32'hFFFF_FFFE);
    rb = rises;
    delay_cycles = 16'd0;
    base_prob = 16'hFFFF;
    decay_shift = 4'd4;
    n0 = cyc;
    exp_q.push_back(n0 + 4);
    light_edge(2);
    tick_until(n0 + 5);
    enable = 1'b0;
    wait_idle(600, t_idle);
    check("t6_idle_no_enable", t_idle, n0 + 260);
    check("t6_enable_gate", rises - rb, 32'd1);
    check("t6_sat_first", pulse_count, 32'hFFFF_FFFF);
    enable = 1'b1;
    tick(5);
    n0 = cyc;
    exp_q.push_back(n0 + 4);
    exp_q.push_back(n0 + 18);
    light_edge(2);
    tick(1);
    wait_idle(600, t_idle);
    check("t6_pulses_ge3", 32'(rises - rb >= 3), 32'd1);
    check("t6_sat_hold", pulse_count, 32'hFFFF_FFFF);
    check("t6_sb_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/photon_pulse_emulator.md
PHOTON_PULSE_EMULATOR -- requirements
Module: photon_pulse_emulator

Interface
REQ-001 Parameter SEED, default 32'hACE1_2468, is the LFSR reset value; 0 is replaced by 1.
REQ-002 Parameter PULSE_WIDTH, default 4, is the emitted pulse high time in clocks (1..255).
REQ-003 Parameter DEAD_TIME, default 10, is the forced-low clocks after each pulse (0..255).
REQ-004 main_clock  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 light_in  input  1  asynchronous excitation modulation (driven from the light source pin).
REQ-007 enable  input  1  high permits photon emission; low forces pmt_out low after the current pulse.
REQ-008 delay_cycles  input  16  clocks from synchronized light_in rising edge to decay start.
REQ-009 decay_shift  input  4  decay step length is 2^decay_shift clocks.
REQ-010 base_prob  input  16  per-clock emission threshold at decay start.
REQ-011 dark_prob  input  16  per-clock dark-count threshold.
REQ-012 pmt_out  output  1  emulated PMT pulse train (drives the counter's PMT input).
REQ-013 pulse_count  output  32  total pulses emitted since reset, saturating.
REQ-014 busy  output  1  high in states DELAY or DECAY.

Function
REQ-015 light_in shall pass a 2-flop synchronizer; a rising edge is detected on the synchronized signal, adding 3 clocks of latency to the edge event.
REQ-016 A 32-bit Galois LFSR (x^32+x^22+x^2+x+1) shall advance every clock; rnd = LFSR[15:0].
REQ-017 States: IDLE, DELAY, DECAY; reset enters IDLE.
REQ-018 IDLE -> DELAY on detected edge; delay counter loads delay_cycles; delay_cycles=0 goes directly IDLE -> DECAY.
REQ-019 DELAY decrements each clock; at count 1 transition to DECAY next clock with elapsed=0.
REQ-020 DECAY: elapsed increments each clock; prob = base_prob >> (elapsed >> decay_shift), shift amounts >=16 yield 0.
REQ-021 DECAY -> IDLE when prob = 0 or elapsed reaches 16<<decay_shift, whichever first.
REQ-022 A detected edge in DELAY or DECAY shall restart DELAY with delay_cycles (retrigger; old decay discarded).
REQ-023 Fire condition per clock: enable and emitter idle and ((DECAY and rnd < prob) or dark event).
REQ-024 Emitter: on fire, pmt_out high the next clock for exactly PULSE_WIDTH clocks, then low for DEAD_TIME clocks; no fire evaluated during either.
REQ-025 Simultaneous decay and dark fire produce one pulse and increment pulse_count by 1.
REQ-026 pulse_count increments on each pmt_out rising edge and saturates at 32'hFFFF_FFFF.
REQ-027 enable deasserted mid-pulse shall not truncate the pulse or dead time.
REQ-028 State machine shall run regardless of enable; only firing is gated.

Reset
REQ-029 On reset: state IDLE, pmt_out 0, pulse_count 0, busy 0, LFSR = SEED (or 1), synchronizer flops 0, all counters 0.
REQ-030 Reset mid-pulse shall drop pmt_out to 0 on the next clock with no count increment.

Configuration
REQ-031 Macro EMU_DARK_COUNT_EN defined: dark event = (rnd < dark_prob), evaluated in every state.
REQ-032 Macro EMU_DARK_COUNT_EN undefined: dark event constant 0; dark_prob port present and ignored.

Verification
REQ-033 delay_cycles=100, base_prob=16'hFFFF, decay_shift=4, PULSE_WIDTH=4, DEAD_TIME=10, single light_in edge -> first pmt_out rise exactly 3+100+1 clocks after edge, pulses 4 high / 10 low until prob falls.
REQ-034 base_prob=0, dark_prob=0, 1000 edges -> pmt_out never high, pulse_count 0, busy toggles per edge.
REQ-035 Second light_in edge 50 clocks into DECAY with delay_cycles=20 -> busy stays 1, no fire for 20 clocks after re-detected edge, decay restarts from elapsed 0.
REQ-036 EMU_DARK_COUNT_EN defined, dark_prob=16'hFFFF, light_in static 0 -> continuous 4-high/10-low train; undefined -> no pulses.
REQ-037 Reset asserted on 2nd clock of a pulse -> pmt_out 0 next clock, pulse_count 0, LFSR equals SEED.
REQ-038 pulse_count forced near saturation (via long dark run or backdoor 32'hFFFF_FFFE), 3 further pulses -> pulse_count holds 32'hFFFF_FFFF.
